// File: rtl/key_schedule_if.sv
// key_schedule_if: round-stage, control and key-store read signals of the key schedule controller
interface key_schedule_if;
  logic         START;
  logic [0:127] CIPHER_KEY;
  logic [0:127] ROUND_PREV_KEY;
  logic [0:31]  ROUND_RCON;
  logic [0:127] ROUND_NEW_KEY;
  logic         BUSY;
  logic         DONE;
  logic         KEY_VALID;
  logic [3:0]   RD_ADDR;
  logic [0:127] RD_KEY;
  modport slave (
    input  START, CIPHER_KEY, ROUND_NEW_KEY, RD_ADDR,
    output ROUND_PREV_KEY, ROUND_RCON, BUSY, DONE, KEY_VALID, RD_KEY
  );
  modport master (
    output START, CIPHER_KEY, ROUND_NEW_KEY, RD_ADDR,
    input  ROUND_PREV_KEY, ROUND_RCON, BUSY, DONE, KEY_VALID, RD_KEY
  );
endinterface

// File: rtl/key_schedule_controller.sv
// key_schedule_controller: sequences AES-128 key expansion over ten rounds and buffers K0..K10
module key_schedule_controller #(
  parameter int SUBWORD_LATENCY = 1
) (
  input logic         CLK,
  input logic         RST,
  key_schedule_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_DONE} state_t;
  // with no SubWord latency the round stage answers combinationally, so WAIT is skipped
  localparam state_t S_FIRST = (SUBWORD_LATENCY == 0) ? S_CAPT : S_WAIT;
  state_t       state, state_nx;
  logic [3:0]   round;
  logic [1:0]   cnt;
  logic [0:127] prev;
  logic [0:7]   rc;
  logic         busy, done, key_valid;
  logic [0:127] store [0:10];
  logic         go, last;
  assign go   = (state == S_IDLE || state == S_DONE) && bus.START;
  assign last = round == 4'd10;
  always_comb begin
    state_nx = go ? S_FIRST
             : state == S_WAIT ? (cnt == 2'd1 ? S_CAPT : S_WAIT)
             : state == S_CAPT ? (last ? S_DONE : S_FIRST)
             : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      round     <= '0;
      cnt       <= '0;
      prev      <= '0;
      rc        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        store[0]  <= bus.CIPHER_KEY;
        prev      <= bus.CIPHER_KEY;
        rc        <= 8'h01;
        round     <= 4'd1;
        cnt       <= 2'(SUBWORD_LATENCY);
        key_valid <= 1'b0;
        busy      <= 1'b1;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 2'd1;
      end else if (state == S_CAPT) begin
        store[round] <= bus.ROUND_NEW_KEY;
        prev         <= bus.ROUND_NEW_KEY;
        rc           <= {rc[1:7], 1'b0} ^ (rc[0] ? 8'h1b : 8'h00);
        if (last) begin
          busy      <= 1'b0;
          key_valid <= 1'b1;
          done      <= 1'b1;
        end else begin
          round <= round + 4'd1;
          cnt   <= 2'(SUBWORD_LATENCY);
        end
      end
    end
  end
  assign bus.ROUND_PREV_KEY = prev;
  assign bus.ROUND_RCON     = {rc, 24'h0};
  assign bus.BUSY           = busy;
  assign bus.DONE           = done;
  assign bus.KEY_VALID      = key_valid;
  assign bus.RD_KEY         = bus.RD_ADDR <= 4'd10 ? store[bus.RD_ADDR] : '0;
endmodule

// File: tb/tb_key_schedule_controller.sv
// tb_key_schedule_controller: directed and random key schedules checked against an AES-128 expansion model
`timescale 1ns/1ps
module tb_key_schedule_controller;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  key_schedule_if b0 ();
  key_schedule_if b1 ();
  key_schedule_if b3 ();
  key_schedule_controller #(.SUBWORD_LATENCY(0)) d0 (.CLK(CLK), .RST(RST), .bus(b0));
  key_schedule_controller #(.SUBWORD_LATENCY(1)) d1 (.CLK(CLK), .RST(RST), .bus(b1));
  key_schedule_controller #(.SUBWORD_LATENCY(3)) d3 (.CLK(CLK), .RST(RST), .bus(b3));
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [7:0]   sb [256];
  logic [127:0] ek [11];
  logic [7:0]   rct [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int passed = 0;
  int total = 0;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      repeat (254) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction
  // round stage seen by the DUTs: one AES key-expansion step
  function automatic logic [127:0] rs(input logic [127:0] p, input logic [31:0] r);
    logic [31:0] t, n0, n1, n2, n3;
    t  = subw({p[23:0], p[31:24]}) ^ r;
    n0 = p[127:96] ^ t;
    n1 = p[95:64] ^ n0;
    n2 = p[63:32] ^ n1;
    n3 = p[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  logic [127:0] p1;
  logic [127:0] p3 [3];
  assign b0.ROUND_NEW_KEY = rs(b0.ROUND_PREV_KEY, b0.ROUND_RCON);
  assign b1.ROUND_NEW_KEY = p1;
  assign b3.ROUND_NEW_KEY = p3[2];
  always @(posedge CLK) p1 <= rs(b1.ROUND_PREV_KEY, b1.ROUND_RCON);
  always @(posedge CLK) begin
    p3[0] <= rs(b3.ROUND_PREV_KEY, b3.ROUND_RCON);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) ek[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic rd(input int a);
    b0.RD_ADDR = 4'(a);
    b1.RD_ADDR = 4'(a);
    b3.RD_ADDR = 4'(a);
    #1;
  endtask
  task automatic check_store(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd(a);
      chk($sformatf("%s_rd%0d", tag, a), b1.RD_KEY, a <= 10 ? ek[a] : 128'h0);
    end
    tick;
  endtask
  task automatic run1(input string tag, input logic [127:0] key, input bit hold, input logic [127:0] nkey);
    int seen;
    expand(key);
    b1.CIPHER_KEY = key;
    b1.START = 1'b1;
    tick;
    for (int k = 0; k <= 21; k++) begin
      if (k < 20) begin
        chk($sformatf("%s_busy_k%0d", tag, k), b1.BUSY, 1);
        chk($sformatf("%s_done_k%0d", tag, k), b1.DONE, 0);
        chk($sformatf("%s_kv_k%0d", tag, k), b1.KEY_VALID, 0);
        chk($sformatf("%s_rcon_k%0d", tag, k), b1.ROUND_RCON, {rct[k/2], 24'h0});
        chk($sformatf("%s_prev_k%0d", tag, k), b1.ROUND_PREV_KEY, ek[k/2]);
      end else if (k == 20) begin
        chk($sformatf("%s_done_pulse", tag), {b1.DONE, b1.KEY_VALID, b1.BUSY}, 3'b110);
      end else begin
        chk($sformatf("%s_after_done", tag), {b1.DONE, b1.KEY_VALID, b1.BUSY}, hold ? 3'b001 : 3'b010);
      end
      if (k == 0 && !hold) b1.START = 1'b0;
      if (k == 0 && hold) b1.CIPHER_KEY = nkey;
      if (k < 21) tick;
    end
    if (hold) begin
      b1.START = 1'b0;
      seen = 0;
      for (int n = 0; n < 30 && seen == 0; n++) begin
        tick;
        if (b1.DONE) seen = 1;
      end
      chk($sformatf("%s_restart_done", tag), seen, 1);
      expand(nkey);
    end
    check_store(tag);
  endtask
  initial begin
    int n0, n3;
    logic [127:0] rk;
    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
    {b0.START, b1.START, b3.START} = '0;
    {b0.CIPHER_KEY, b1.CIPHER_KEY, b3.CIPHER_KEY} = '0;
    rd(0);
    tick;
    tick;
    RST = 1'b0;
    chk("rst_outputs", {b1.BUSY, b1.DONE, b1.KEY_VALID}, 0);
    chk("rst_prev", b1.ROUND_PREV_KEY, 0);
    chk("rst_rcon", b1.ROUND_RCON, 0);
    for (int a = 0; a < 11; a++) begin
      rd(a);
      chk($sformatf("rst_rd%0d", a), b1.RD_KEY, 0);
    end
    tick;
    run1("fips", FIPS, 0, 0);
    rd(1);
    chk("fips_k1", b1.RD_KEY, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(10);
    chk("fips_k10", b1.RD_KEY, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick;
    run1("zero", 0, 0, 0);
    rd(0);
    chk("zero_k0", b1.RD_KEY, 0);
    rd(1);
    chk("zero_k1", b1.RD_KEY, 128'h62636363626363636263636362636363);
    rd(10);
    chk("zero_k10", b1.RD_KEY, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    tick;
    for (int i = 0; i < 3; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run1($sformatf("rand%0d", i), rk, 0, 0);
    end
    rk = {$urandom, $urandom, $urandom, $urandom};
    run1("hold", FIPS, 1, rk);
    b1.CIPHER_KEY = {$urandom, $urandom, $urandom, $urandom};
    b1.START = 1'b1;
    tick;
    b1.START = 1'b0;
    repeat (8) tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("midrst_outputs", {b1.BUSY, b1.DONE, b1.KEY_VALID}, 0);
    chk("midrst_prev", b1.ROUND_PREV_KEY, 0);
    chk("midrst_rcon", b1.ROUND_RCON, 0);
    for (int a = 0; a < 11; a++) begin
      rd(a);
      chk($sformatf("midrst_rd%0d", a), b1.RD_KEY, 0);
    end
    tick;
    RST = 1'b1;
    b1.START = 1'b1;
    tick;
    RST = 1'b0;
    b1.START = 1'b0;
    chk("rst_over_start", {b1.BUSY, b1.KEY_VALID}, 0);
    tick;
    run1("after_rst", FIPS, 0, 0);
    expand(FIPS);
    b0.CIPHER_KEY = FIPS;
    b3.CIPHER_KEY = FIPS;
    b0.START = 1'b1;
    b3.START = 1'b1;
    tick;
    b0.START = 1'b0;
    b3.START = 1'b0;
    n0 = 0;
    n3 = 0;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (b0.DONE && n0 == 0) n0 = n;
      if (b3.DONE && n3 == 0) n3 = n;
    end
    chk("lat0_done_edge", n0, 10);
    chk("lat3_done_edge", n3, 40);
    for (int a = 0; a < 16; a++) begin
      rd(a);
      chk($sformatf("lat0_rd%0d", a), b0.RD_KEY, a <= 10 ? ek[a] : 128'h0);
      chk($sformatf("lat3_rd%0d", a), b3.RD_KEY, a <= 10 ? ek[a] : 128'h0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
